riscv_mem_arb: RTL

Two-requester arbiter and sequencer for a single-port unified memory shared by the core's instruction-fetch path and load/store path. It accepts one transaction at a time from either requester, drives it onto the memory port, waits for the response and routes it back to the owner. Data accesses have priority over fetches. A starvation counter forces a fetch grant after a bounded run of data grants. The block sits between the fetch/decode front end, the load/store unit and the memory.

---
 rtl/riscv_mem_arb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb: arbitrates one single-port memory between the instruction
// fetch path (I) and the load/store path (D). One transaction is in flight at
// a time. D wins ties unless it has been granted STARVE_LIMIT times in a row
// while a fetch was waiting, in which case the fetch is forced through.
module riscv_mem_arb #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  // fetch requester
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  // load/store requester
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  // status
  output logic            busy,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]    state_reg, state_next;
  logic          own_reg;
  logic [SW-1:0] streak_reg;
  logic          grant_i, grant_d;
  logic          resp_done;

  logic          mem_req_reg;
  logic          mem_we_reg;
  logic [BW-1:0] mem_be_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic          i_gnt_reg, d_gnt_reg;
  logic          i_rvalid_reg, d_rvalid_reg;
  logic [DW-1:0] i_rdata_reg, d_rdata_reg;
  logic          busy_reg;
  logic          err_reg;

  // Response accepted only while waiting for one; anything else is stray.
  assign resp_done = (state_reg == ST_WAIT) && mem_rvalid;

  // Arbitration and next-state selection.
  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (d_req && (!i_req || (streak_reg < STREAK_MAX))) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_d || grant_i) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state plus the registered status flags derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      busy_reg    <= 1'b0;
      mem_req_reg <= 1'b0;
      i_gnt_reg   <= 1'b0;
      d_gnt_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      busy_reg    <= (state_next != ST_IDLE);
      mem_req_reg <= (state_next == ST_ISSUE);
      i_gnt_reg   <= grant_i;
      d_gnt_reg   <= grant_d;
    end
  end

  // Capture the winner's request into the memory-side registers and owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_reg       <= OWN_I;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (grant_d) begin
      own_reg       <= OWN_D;
      mem_we_reg    <= d_we;
      mem_be_reg    <= d_be;
      mem_addr_reg  <= d_addr;
      mem_wdata_reg <= d_wdata;
    end else if (grant_i) begin
      own_reg       <= OWN_I;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= '1;
      mem_addr_reg  <= i_addr;
      mem_wdata_reg <= '0;
    end
  end

  // Count consecutive D grants taken while a fetch was left waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_reg <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        streak_reg <= '0;
      end else if (streak_reg != STREAK_MAX) begin
        streak_reg <= streak_reg + 1'b1;
      end
    end else if (grant_i) begin
      streak_reg <= '0;
    end
  end

  // Route the memory response to the owner; the other side is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
    end else begin
      i_rvalid_reg <= resp_done && (own_reg == OWN_I);
      d_rvalid_reg <= resp_done && (own_reg == OWN_D);
      if (resp_done && (own_reg == OWN_I)) begin
        i_rdata_reg <= mem_rdata;
      end
      if (resp_done && (own_reg == OWN_D)) begin
        d_rdata_reg <= mem_rdata;
      end
    end
  end

  // Sticky flag for responses or grants the memory should never have sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((mem_rvalid && (state_reg != ST_WAIT)) || (mem_gnt && !mem_req_reg)) begin
      err_reg <= 1'b1;
    end
  end

  assign i_gnt     = i_gnt_reg;
  assign d_gnt     = d_gnt_reg;
  assign i_rvalid  = i_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule
